// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Waits for a stable PLL lock, then releases a chain of active-low reset
// outputs one stage at a time (bit 0 first), and reports when every stage is
// out of reset. Loss of lock or a software reset request pulls every stage
// back into reset together and restarts the sequence.
//
// Parameters
//   N_STAGES     number of sequenced reset outputs (1..8)
//   LOCK_DLY     consecutive synchronized-lock cycles required before release
//   STAGE_DLY    cycles between successive stage releases
//   LOCK_TIMEOUT WAIT_LOCK cycles before timeout_o is raised (macro build only)
//
// Ports
//   clk_i         single clock
//   rst_ni        asynchronous active-low reset
//   pll_locked_i  PLL lock, asynchronous to clk_i (synchronized internally)
//   sw_rst_i      synchronous software reset request, sampled every cycle
//   rst_no        per-stage active-low resets, bit 0 released first
//   ready_o       all stages released
//   timeout_o     sticky lock-timeout flag
//
// Build option
//   RESET_SEQUENCER_TIMEOUT_EN  when defined, a timeout counter tracks time
//                               spent in WAIT_LOCK and drives timeout_o;
//                               otherwise timeout_o is tied low.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int unsigned N_STAGES     = 3,
    parameter int unsigned LOCK_DLY     = 16,
    parameter int unsigned STAGE_DLY    = 8,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pll_locked_i,
    input  logic                sw_rst_i,
    output logic [N_STAGES-1:0] rst_no,
    output logic                ready_o,
    output logic                timeout_o
);

    // One counter width covers every delay so no counter can wrap.
    localparam int unsigned MAX_LS  = (LOCK_DLY > STAGE_DLY) ? LOCK_DLY : STAGE_DLY;
    localparam int unsigned MAX_DLY = (MAX_LS > LOCK_TIMEOUT) ? MAX_LS : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);
    localparam int unsigned IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_DLY - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_STAGES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic                lock_s;
    logic                abort;
    logic                lock_done;
    logic                stage_tick;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_STAGES-1:0] rst_q, rst_d;
    logic                ready_q, ready_d;

    // -------------------------------------------------------------------------
    // Two-flop lock synchronizer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pll_locked_i};
        end
    end

    assign lock_s = sync_q[1];

    // Lock loss and software reset are the same abort condition.
    assign abort      = !lock_s || sw_rst_i;
    assign lock_done  = !abort && (cnt_q == LOCK_LAST);
    assign stage_tick = (cnt_q == STAGE_LAST);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_done) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (abort) begin
                    state_d = WAIT_LOCK;
                end else if (stage_tick && (idx_q == IDX_LAST)) begin
                    // RUN is entered on the same edge the last stage releases.
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                rst_d = '0;
                idx_d = '0;
                if (abort || lock_done) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (abort) begin
                    cnt_d = '0;
                    idx_d = '0;
                    rst_d = '0;
                end else if (stage_tick) begin
                    cnt_d = '0;
                    // Shifting a 1 in from the bottom releases stages in
                    // index order and never drops an already released one.
                    rst_d = N_STAGES'({rst_q, 1'b1});
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_d = '0;
                    idx_d = '0;
                    rst_d = '0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                idx_d = '0;
                rst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    assign rst_no  = rst_q;
    assign ready_o = ready_q;

    // -------------------------------------------------------------------------
    // Optional lock timeout: observes the FSM, never influences it.
    // -------------------------------------------------------------------------
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(LOCK_TIMEOUT);

    logic [CNT_W-1:0] tcnt_q;
    logic             timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == WAIT_LOCK) begin
            if (state_d == RELEASE) begin
                tcnt_q    <= '0;
                timeout_q <= 1'b0;
            end else if (tcnt_q != TO_MAX) begin
                // Saturates at LOCK_TIMEOUT; the flag stays set until release.
                tcnt_q <= tcnt_q + 1'b1;
                if (tcnt_q == TO_LAST) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Self-checking bench for reset_sequencer (N_STAGES=3, LOCK_DLY=4,
// STAGE_DLY=2, LOCK_TIMEOUT=16). The reference model tracks only "waiting
// for lock" versus "cycles elapsed since release began" and derives the
// expected outputs arithmetically from that elapsed count.
// Build option: RESET_SEQUENCER_TIMEOUT_EN selects the expected timeout_o.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int unsigned N_STAGES     = 3;
    localparam int unsigned LOCK_DLY     = 4;
    localparam int unsigned STAGE_DLY    = 2;
    localparam int unsigned LOCK_TIMEOUT = 16;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    logic                clk    = 1'b0;
    logic                rst_n  = 1'b1;
    logic                pll    = 1'b0;
    logic                sw     = 1'b0;
    logic [N_STAGES-1:0] rst_no;
    logic                ready;
    logic                tmo;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_s1, m_s2;
    bit m_in_seq;
    int m_lock_run;
    int m_elapsed;
    int m_wait;
    bit m_to;

    always #5 clk = ~clk;

    reset_sequencer #(
        .N_STAGES     (N_STAGES),
        .LOCK_DLY     (LOCK_DLY),
        .STAGE_DLY    (STAGE_DLY),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pll_locked_i (pll),
        .sw_rst_i     (sw),
        .rst_no       (rst_no),
        .ready_o      (ready),
        .timeout_o    (tmo)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1       = 1'b0;
        m_s2       = 1'b0;
        m_in_seq   = 1'b0;
        m_lock_run = 0;
        m_elapsed  = 0;
        m_wait     = 0;
        m_to       = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs held before it.
    task automatic model_edge();
        bit lock_s;
        bit abort;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lock_s = m_s2;
        m_s2   = m_s1;
        m_s1   = pll;
        abort  = !lock_s || sw;
        if (m_in_seq) begin
            if (abort) begin
                m_in_seq   = 1'b0;
                m_lock_run = 0;
            end else if (m_elapsed < 1000) begin
                m_elapsed++;
            end
        end else begin
            if (abort) m_lock_run = 0;
            else       m_lock_run++;
            if (m_lock_run == LOCK_DLY) begin
                m_in_seq   = 1'b1;
                m_elapsed  = 0;
                m_lock_run = 0;
                m_wait     = 0;
                m_to       = 1'b0;
            end else begin
                if (m_wait < LOCK_TIMEOUT) m_wait++;
                if (m_wait >= LOCK_TIMEOUT) m_to = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] exp_rst();
        int n;
        if (!m_in_seq) return 32'd0;
        n = m_elapsed / STAGE_DLY;
        if (n > N_STAGES) n = N_STAGES;
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic logic [31:0] exp_ready();
        return {31'd0, m_in_seq && (m_elapsed >= N_STAGES * STAGE_DLY + 1)};
    endfunction

    function automatic logic [31:0] exp_to();
        return {31'd0, TO_EXP && m_to};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("rst_no",  32'(rst_no), exp_rst());
        check_eq("ready_o", 32'(ready),  exp_ready());
        check_eq("timeout", 32'(tmo),    exp_to());
    endtask

    // Asynchronous reset: outputs must clear with no clock edge in between.
    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_no",  32'(rst_no), 32'd0);
        check_eq("async_ready",   32'(ready),  32'd0);
        check_eq("async_timeout", 32'(tmo),    32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bit hit;
        model_reset();

        // Steady lock from reset release: full release sequence.
        pll = 1'b1;
        #2;
        apply_reset();
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 7)  check_eq("a_before_first", 32'(rst_no), 32'd0);
            if (i == 8)  check_eq("a_stage0",       32'(rst_no), 32'd1);
            if (i == 10) check_eq("a_stage1",       32'(rst_no), 32'd3);
            if (i == 12) begin
                check_eq("a_all",        32'(rst_no), 32'd7);
                check_eq("a_ready_late", 32'(ready),  32'd0);
            end
            if (i == 13) check_eq("a_ready", 32'(ready), 32'd1);
        end

        // Lock lost in RUN: all stages assert three edges after the fall.
        pll = 1'b0;
        step();
        step();
        check_eq("b_hold", 32'(rst_no), 32'd7);
        step();
        check_eq("b_drop_rst",   32'(rst_no), 32'd0);
        check_eq("b_drop_ready", 32'(ready),  32'd0);
        pll = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check_eq("b_resume_rst",   32'(rst_no), 32'd7);
        check_eq("b_resume_ready", 32'(ready),  32'd1);

        // Software reset pulse while only stage 0 is released.
        apply_reset();
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (exp_rst() == 32'd1) hit = 1'b1;
        end
        check_eq("c_reach_001", 32'(hit), 32'd1);
        sw = 1'b1;
        step();
        sw = 1'b0;
        check_eq("c_sw_drop", 32'(rst_no), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 5) check_eq("c_wait", 32'(rst_no), 32'd0);
            if (i == 6) check_eq("c_rerelease", 32'(rst_no), 32'd1);
        end

        // Asynchronous reset in the middle of RELEASE.
        apply_reset();
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (exp_rst() == 32'd3) hit = 1'b1;
        end
        check_eq("d_reach_011", 32'(hit), 32'd1);
        apply_reset();

        // One-cycle lock glitch at lock count 3 delays release by 4 cycles.
        for (int i = 1; i <= 14; i++) begin
            step();
            pll = (i == 3) ? 1'b0 : 1'b1;
            if (i == 8)  check_eq("e_delayed", 32'(rst_no), 32'd0);
            if (i == 11) check_eq("e_wait",    32'(rst_no), 32'd0);
            if (i == 12) check_eq("e_stage0",  32'(rst_no), 32'd1);
        end

        // No lock: timeout behaviour, then clear on RELEASE entry.
        pll = 1'b0;
        apply_reset();
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 15) check_eq("f_to_early", 32'(tmo), 32'd0);
            if (i == 16) check_eq("f_to_set",   32'(tmo), 32'(TO_EXP));
            if (i == 20) pll = 1'b1;
            if (i == 25) check_eq("f_to_sticky", 32'(tmo), 32'(TO_EXP));
            if (i == 26) check_eq("f_to_clear",  32'(tmo), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step();
            sw = ($urandom_range(0, 29) == 0);
            if (pll) pll = ($urandom_range(0, 59) != 0);
            else     pll = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                pll = 1'b0;
                for (int j = 0; j < 20; j++) step();
            end
            if ($urandom_range(0, 399) == 0) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
